// File: rtl/fetch_stage.sv
// ============================================================================
// Module   : fetch_stage
// Purpose  : MIPS instruction-fetch stage. Holds the PC, drives the masked
//            byte address to instruction memory and registers the returned
//            word with PC+4 into the IF/ID pipeline register. Handles stalls,
//            flushes and ID-stage branch/jump redirects (no delay slots).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = 4096,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  input  logic        jump,
  input  logic [31:0] jumpTarget,
  input  logic [31:0] instruction,
  output logic [31:0] instructionAddress,
  output logic [31:0] ifIdInstruction,
  output logic [31:0] ifIdPcPlus4,
  output logic        ifIdValid,
  output logic [15:0] fetchCount
);

  // Word-aligned wrap mask for the instruction memory address space.
  localparam logic [31:0] ADDR_MASK = 32'(MEM_BYTES - 1) & 32'hFFFF_FFFC;

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        redirect;
  logic        accept;

  assign pc_plus4           = pc + 32'd4;
  assign redirect           = branchTaken | jump;
  // A word is accepted into IF/ID only when nothing squashes or holds it.
  assign accept             = ~(flush | redirect) & ~stall;
  assign instructionAddress = pc & ADDR_MASK;

  // Next-PC selection: branch beats jump, any redirect beats stall.
  always_comb begin
    next_pc = pc_plus4;
    if (branchTaken) begin
      next_pc = branchTarget & 32'hFFFF_FFFC;
    end else if (jump) begin
      next_pc = jumpTarget & 32'hFFFF_FFFC;
    end else if (stall) begin
      next_pc = pc;
    end
  end

  // Program counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else begin
      pc <= next_pc;
    end
  end

  // IF/ID pipeline register: bubble on flush/redirect, hold on stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ifIdInstruction <= NOP_WORD;
      ifIdPcPlus4     <= 32'd0;
      ifIdValid       <= 1'b0;
    end else if (flush || redirect) begin
      ifIdInstruction <= NOP_WORD;
      ifIdPcPlus4     <= 32'd0;
      ifIdValid       <= 1'b0;
    end else if (!stall) begin
      ifIdInstruction <= instruction;
      ifIdPcPlus4     <= pc_plus4;
      ifIdValid       <= 1'b1;
    end
  end

  // Count of instructions accepted into IF/ID, wrapping at 16 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetchCount <= 16'd0;
    end else if (accept) begin
      fetchCount <= fetchCount + 16'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Self-checking bench for fetch_stage using a table of directed
//            vectors plus hand-written async-reset and counter-wrap sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic        jump;
  logic [31:0] jumpTarget;
  logic [31:0] instruction;
  logic [31:0] instructionAddress;
  logic [31:0] ifIdInstruction;
  logic [31:0] ifIdPcPlus4;
  logic        ifIdValid;
  logic [15:0] fetchCount;

  int compared;
  int mismatched;

  logic [7:0] mem [0:4095];

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .MEM_BYTES(4096),
    .NOP_WORD (32'h0000_0000)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .flush             (flush),
    .branchTaken       (branchTaken),
    .branchTarget      (branchTarget),
    .jump              (jump),
    .jumpTarget        (jumpTarget),
    .instruction       (instruction),
    .instructionAddress(instructionAddress),
    .ifIdInstruction   (ifIdInstruction),
    .ifIdPcPlus4       (ifIdPcPlus4),
    .ifIdValid         (ifIdValid),
    .fetchCount        (fetchCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Big-endian instruction memory model.
  assign instruction = {mem[instructionAddress[11:0]],
                        mem[instructionAddress[11:0] + 12'd1],
                        mem[instructionAddress[11:0] + 12'd2],
                        mem[instructionAddress[11:0] + 12'd3]};

  // Memory contents: address 0 holds AA0F5533, other words are address-tagged.
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a == 32'd0) ? 32'hAA0F_5533 : (32'h1357_0000 ^ a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] a, input logic [31:0] ins,
                         input logic [31:0] p4, input logic v, input logic [15:0] c);
    chk({tag, ".addr"},  instructionAddress, a);
    chk({tag, ".instr"}, ifIdInstruction, ins);
    chk({tag, ".pcp4"},  ifIdPcPlus4, p4);
    chk({tag, ".valid"}, {31'd0, ifIdValid}, {31'd0, v});
    chk({tag, ".count"}, {16'd0, fetchCount}, {16'd0, c});
  endtask

  typedef struct {
    logic        st;
    logic        fl;
    logic        br;
    logic [31:0] brt;
    logic        jp;
    logic [31:0] jpt;
    logic [31:0] e_addr;
    logic [31:0] e_instr;
    logic [31:0] e_pcp4;
    logic        e_valid;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs [17];

  task automatic set_in(input logic st, input logic fl, input logic br, input logic [31:0] brt,
                        input logic jp, input logic [31:0] jpt);
    stall = st; flush = fl; branchTaken = br; branchTarget = brt; jump = jp; jumpTarget = jpt;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    for (int i = 0; i < 4096; i += 4) begin
      logic [31:0] w;
      w = word_of(32'(i));
      mem[i] = w[31:24]; mem[i+1] = w[23:16]; mem[i+2] = w[15:8]; mem[i+3] = w[7:0];
    end

    //            st    fl    br    brt           jp    jpt           addr          instr                pcp4          v     cnt
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       32'h4,        32'hAA0F_5533,       32'h4,        1'b1, 16'd1};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       32'h8,        word_of(32'h4),      32'h8,        1'b1, 16'd2};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       32'h8,        word_of(32'h4),      32'h8,        1'b1, 16'd2};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       32'h8,        word_of(32'h4),      32'h8,        1'b1, 16'd2};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       32'h8,        word_of(32'h4),      32'h8,        1'b1, 16'd2};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       32'hC,        word_of(32'h8),      32'hC,        1'b1, 16'd3};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       32'h10,       word_of(32'hC),      32'h10,       1'b1, 16'd4};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 32'h102,     1'b0, 32'h0,       32'h100,      32'h0,               32'h0,        1'b0, 16'd4};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       32'h104,      word_of(32'h100),    32'h104,      1'b1, 16'd5};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'h40,      1'b1, 32'h80,      32'h40,       32'h0,               32'h0,        1'b0, 16'd5};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       32'h44,       word_of(32'h40),     32'h44,       1'b1, 16'd6};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 32'h0,       1'b0, 32'h0,       32'h44,       32'h0,               32'h0,        1'b0, 16'd6};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 32'h0,       1'b0, 32'h0,       32'h48,       32'h0,               32'h0,        1'b0, 16'd6};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 32'hFFC,     32'hFFC,      32'h0,               32'h0,        1'b0, 16'd6};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       32'h0,        word_of(32'hFFC),    32'h1000,     1'b1, 16'd7};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       32'h4,        32'hAA0F_5533,       32'h1004,     1'b1, 16'd8};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 32'h23,      32'h20,       32'h0,               32'h0,        1'b0, 16'd8};

    set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 16'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 17; i++) begin
      set_in(vecs[i].st, vecs[i].fl, vecs[i].br, vecs[i].brt, vecs[i].jp, vecs[i].jpt);
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_instr,
              vecs[i].e_pcp4, vecs[i].e_valid, vecs[i].e_cnt);
      @(negedge clk);
    end
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    // Run a couple of cycles so state is non-reset, then reset between edges.
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk_all("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 16'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_all("restart", 32'h4, 32'hAA0F_5533, 32'h4, 1'b1, 16'd1);

    // Free-run until the 16-bit fetch counter wraps back to zero.
    repeat (65535) @(posedge clk);
    #1;
    chk("count_wrap", {16'd0, fetchCount}, 32'd0);
    chk("wrap_valid", {31'd0, ifIdValid}, 32'd1);
    @(posedge clk);
    #1;
    chk("count_after_wrap", {16'd0, fetchCount}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
